// File: rtl/vblank_arbiter.sv
// Round-robin, one-hot grant arbiter confined to the guarded vertical-blanking window.
// Optional saturating revoke counter is enabled by defining VBLANK_ARB_OVERRUN_CNT_EN.
module vblank_arbiter #(
   parameter int unsigned N_REQ            = 2,
   parameter int unsigned VBLANK_START     = 900,
   parameter int unsigned VTOTAL           = 926,
   parameter int unsigned GUARD_LINES      = 4,
   parameter int unsigned MAX_GRANT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      vcount,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] gnt,
   output logic             frame_tick,
   output logic             overrun,
   output logic [7:0]       overrun_cnt
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = (MAX_GRANT_CYCLES > 1) ? $clog2(MAX_GRANT_CYCLES) : 1;
   localparam logic [10:0]   WIN_LO   = 11'(VBLANK_START);
   localparam logic [10:0]   WIN_HI   = 11'(VTOTAL - GUARD_LINES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_GRANT_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_WIN = 2'd0,
      ARB      = 2'd1,
      GRANT    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             win_c, win_q, open_c;
   logic [N_REQ-1:0] served_q, served_d;
   logic [N_REQ-1:0] gnt_d;
   logic [IW-1:0]    rr_q, rr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             frame_tick_d, overrun_d;

   logic [N_REQ-1:0] eligible;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [IW:0]      sum;
   logic [IW-1:0]    cand;
   logic [IW-1:0]    rr_next;

   assign win_c   = (vcount >= WIN_LO) && (vcount < WIN_HI);
   assign open_c  = win_c & ~win_q;
   assign rr_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

   // First eligible requester searching upward from rr_q with wrap.
   always_comb begin
      eligible   = req & ~served_q;
      pick_found = 1'b0;
      pick_idx   = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
         end
         cand = IW'(sum);
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      served_d     = served_q;
      rr_d         = rr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt;
      overrun_d    = 1'b0;
      frame_tick_d = open_c;

      case (state_q)
         WAIT_WIN: begin
            gnt_d = '0;
         end
         ARB: begin
            gnt_d = '0;
            if (!win_q) begin
               state_d = WAIT_WIN;
            end else if (pick_found) begin
               gnt_d[pick_idx] = 1'b1;
               owner_d         = pick_idx;
               cnt_d           = '0;
               state_d         = GRANT;
            end
         end
         GRANT: begin
            // done beats timeout beats window close
            if (|(done & gnt)) begin
               gnt_d             = '0;
               served_d[owner_q] = 1'b1;
               rr_d              = rr_next;
               state_d           = ARB;
            end else if (cnt_q == CNT_LAST) begin
               gnt_d             = '0;
               served_d[owner_q] = 1'b1;
               rr_d              = rr_next;
               overrun_d         = 1'b1;
               state_d           = ARB;
            end else if (!win_q) begin
               gnt_d             = '0;
               served_d[owner_q] = 1'b1;
               overrun_d         = 1'b1;
               state_d           = WAIT_WIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = WAIT_WIN;
         end
      endcase

      if (open_c) begin
         state_d  = ARB;
         served_d = '0;
         gnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_WIN;
         win_q      <= 1'b0;
         served_q   <= '0;
         rr_q       <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         gnt        <= '0;
         frame_tick <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_c;
         served_q   <= served_d;
         rr_q       <= rr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         gnt        <= gnt_d;
         frame_tick <= frame_tick_d;
         overrun    <= overrun_d;
      end
   end

`ifdef VBLANK_ARB_OVERRUN_CNT_EN
   logic [7:0] ocnt_q;

   // Saturating count of forced revokes, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ocnt_q <= 8'd0;
      end else if (overrun_d && (ocnt_q != 8'hFF)) begin
         ocnt_q <= ocnt_q + 8'd1;
      end
   end

   assign overrun_cnt = ocnt_q;
`else
   assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vblank_arbiter.sv
// Directed bench for vblank_arbiter: window timing, round-robin, timeout, close revoke, reset.
module tb_vblank_arbiter;

`ifdef VBLANK_ARB_OVERRUN_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] vcount;
   logic [1:0]  req;
   logic [1:0]  done;
   logic [1:0]  gnt;
   logic        frame_tick;
   logic        overrun;
   logic [7:0]  overrun_cnt;

   int errors = 0;
   int checks = 0;

   int   grants[$];
   int   ticks, tick_v, ovr_seen, ovr_v, run, last_run, drop_v, age;
   int   done_after, req_from, multi_hot;
   int   g0, g1;
   logic [1:0] req_pat, prev_gnt;
   logic [7:0] exp_cnt;

   vblank_arbiter #(
      .N_REQ(2), .VBLANK_START(900), .VTOTAL(926),
      .GUARD_LINES(4), .MAX_GRANT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .vcount(vcount), .req(req), .done(done),
      .gnt(gnt), .frame_tick(frame_tick), .overrun(overrun), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      grants.delete();
      ticks = 0; tick_v = -1; ovr_seen = 0; ovr_v = -1;
      run = 0; last_run = 0; drop_v = -1; age = 0; prev_gnt = 2'b00;
   endtask

   // One clock with vcount=v; logs outputs and plays the requester side.
   task automatic cyc(input int v);
      vcount = 11'(v);
      req    = (v >= req_from) ? req_pat : 2'b00;
      tick();
      done = 2'b00;
      if ($countones(gnt) > 1) multi_hot++;
      if (frame_tick) begin ticks++; tick_v = v; end
      if (overrun) begin ovr_seen++; ovr_v = v; end
      if (gnt != 2'b00) begin
         if (gnt != prev_gnt) begin grants.push_back(gnt[1] ? 1 : 0); age = 0; end
         age++;
         run++;
         if (done_after != 0 && age == done_after) done = gnt;
      end else if (prev_gnt != 2'b00) begin
         last_run = run; run = 0; drop_v = v;
      end
      prev_gnt = gnt;
   endtask

   task automatic run_frame(input logic [1:0] pat, input int from, input int dly);
      req_pat = pat; req_from = from; done_after = dly;
      clear_log();
      for (int v = 0; v < 926; v++) cyc(v);
      g0 = (grants.size() > 0) ? grants[0] : -1;
      g1 = (grants.size() > 1) ? grants[1] : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; vcount = '0; req = '0; done = '0;
      req_pat = '0; req_from = 0; done_after = 0; multi_hot = 0;
      repeat (3) tick();
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", overrun_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_idle_frame();
      run_frame(2'b00, 0, 0);
      checks++; if (ticks !== 1) begin errors++; $display("FAIL idle_ticks: got %0d want 1", ticks); end
      checks++; if (tick_v !== 900) begin errors++; $display("FAIL idle_tick_line: got %0d want 900", tick_v); end
      checks++; if (grants.size() !== 0) begin errors++; $display("FAIL idle_grants: got %0d want 0", grants.size()); end
   endtask

   task automatic test_round_robin();
      run_frame(2'b11, 0, 3);
      checks++; if (grants.size() !== 2) begin errors++; $display("FAIL rr1_count: got %0d want 2", grants.size()); end
      checks++; if (g0 !== 0 || g1 !== 1) begin errors++; $display("FAIL rr1_order: got %0d,%0d want 0,1", g0, g1); end
      checks++; if (last_run !== 3) begin errors++; $display("FAIL rr1_len: got %0d want 3", last_run); end
      checks++; if (ovr_seen !== 0) begin errors++; $display("FAIL rr1_overrun: got %0d want 0", ovr_seen); end
      run_frame(2'b01, 0, 3);
      checks++; if (grants.size() !== 1 || g0 !== 0) begin errors++; $display("FAIL rr2_single: got n=%0d first=%0d want n=1 first=0", grants.size(), g0); end
      run_frame(2'b11, 0, 3);
      checks++; if (grants.size() !== 2) begin errors++; $display("FAIL rr3_count: got %0d want 2", grants.size()); end
      checks++; if (g0 !== 1 || g1 !== 0) begin errors++; $display("FAIL rr3_order: got %0d,%0d want 1,0", g0, g1); end
   endtask

   task automatic test_timeout();
      run_frame(2'b01, 0, 0);
      exp_cnt = CNT_EN ? 8'd1 : 8'd0;
      checks++; if (grants.size() !== 1) begin errors++; $display("FAIL to_count: got %0d want 1", grants.size()); end
      checks++; if (last_run !== 16) begin errors++; $display("FAIL to_len: got %0d want 16", last_run); end
      checks++; if (ovr_seen !== 1 || ovr_v !== 917) begin errors++; $display("FAIL to_overrun: got n=%0d line=%0d want n=1 line=917", ovr_seen, ovr_v); end
      checks++; if (overrun_cnt !== exp_cnt) begin errors++; $display("FAIL to_cnt: got %0d want %0d", overrun_cnt, exp_cnt); end
   endtask

   task automatic test_window_close();
      run_frame(2'b01, 915, 0);
      exp_cnt = CNT_EN ? 8'd2 : 8'd0;
      checks++; if (grants.size() !== 1) begin errors++; $display("FAIL close_count: got %0d want 1", grants.size()); end
      checks++; if (last_run !== 8) begin errors++; $display("FAIL close_len: got %0d want 8", last_run); end
      checks++; if (drop_v !== 923) begin errors++; $display("FAIL close_drop: got %0d want 923", drop_v); end
      checks++; if (ovr_seen !== 1 || ovr_v !== 923) begin errors++; $display("FAIL close_overrun: got n=%0d line=%0d want n=1 line=923", ovr_seen, ovr_v); end
      checks++; if (overrun_cnt !== exp_cnt) begin errors++; $display("FAIL close_cnt: got %0d want %0d", overrun_cnt, exp_cnt); end
      run_frame(2'b01, 0, 3);
      checks++; if (grants.size() !== 1 || g0 !== 0) begin errors++; $display("FAIL close_next: got n=%0d first=%0d want n=1 first=0", grants.size(), g0); end
      checks++; if (last_run !== 3) begin errors++; $display("FAIL close_next_len: got %0d want 3", last_run); end
   endtask

   task automatic test_done_at_close();
      run_frame(2'b01, 915, 8);
      exp_cnt = CNT_EN ? 8'd2 : 8'd0;
      checks++; if (drop_v !== 923) begin errors++; $display("FAIL dc_drop: got %0d want 923", drop_v); end
      checks++; if (ovr_seen !== 0) begin errors++; $display("FAIL dc_overrun: got %0d want 0", ovr_seen); end
      checks++; if (last_run !== 8) begin errors++; $display("FAIL dc_len: got %0d want 8", last_run); end
      checks++; if (overrun_cnt !== exp_cnt) begin errors++; $display("FAIL dc_cnt: got %0d want %0d", overrun_cnt, exp_cnt); end
   endtask

   task automatic test_reset_mid_grant();
      req_pat = 2'b11; req_from = 0; done_after = 0;
      clear_log();
      for (int v = 0; v < 904; v++) cyc(v);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rm_pre_gnt: got %b want 10", gnt); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rm_async_gnt: got %b want 00", gnt); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rm_cnt: got %0d want 0", overrun_cnt); end
      cyc(904);
      cyc(904);
      rst = 1'b0;
      cyc(905);
      checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL rm_tick: got %b want 1", frame_tick); end
      cyc(906);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_first_gnt: got %b want 01", gnt); end
      for (int v = 907; v < 926; v++) cyc(v);
      checks++; if (multi_hot !== 0) begin errors++; $display("FAIL onehot: got %0d multi-hot cycles want 0", multi_hot); end
   endtask

   initial begin
      test_reset();
      test_idle_frame();
      test_round_robin();
      test_timeout();
      test_window_close();
      test_done_at_close();
      test_reset_mid_grant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vblank_arbiter.md
# vblank_arbiter

Schedules access to the shared board-state / frame resources between up to N_REQ requesters, granting them only inside a guarded vertical-blanking window derived from the VGA timing generator's vcount. It sits between the timing generator and the game-logic, mouse and overlay update engines. Grants are round-robin and one-hot. Each requester is served at most once per frame. Grants that run too long, or that are still active when the window closes, are forcibly revoked.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4)
- VBLANK_START, 900, first blank line
- VTOTAL, 926, total lines per frame
- GUARD_LINES, 4, lines at the end of vblank in which no grant may be active
- MAX_GRANT_CYCLES, 1024, maximum cycles gnt may stay high

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- vcount  in  11  current line, 0..VTOTAL-1, from the timing generator
- req  in  N_REQ  level request, held until granted
- done  in  N_REQ  single-cycle pulse from the granted requester
- gnt  out  N_REQ  one-hot grant, registered
- frame_tick  out  1  one-cycle pulse when the window opens
- overrun  out  1  one-cycle pulse on forced revoke
- overrun_cnt  out  8  saturating revoke count (see Configuration)

## Operation
- Window: win = (vcount >= VBLANK_START) && (vcount < VTOTAL - GUARD_LINES). It is registered each cycle into win_q.
- Window open is the win_q 0->1 transition. On window open:
  - frame_tick is pulsed.
  - The served mask is cleared.
  - FSM goes to ARB.
- States:
  - WAIT_WIN: gnt=0. On window open -> ARB.
  - ARB:
    - If !win_q -> WAIT_WIN.
    - Else, eligible = req & ~served. If eligible is nonzero, pick the first eligible index searching upward (with wrap) from rr_ptr. Set gnt to that one-hot value, clear the cycle counter -> GRANT.
    - If eligible is zero, stay in ARB.
  - GRANT (owner i):
    - done[i] -> gnt=0, served[i]=1, rr_ptr=(i+1) mod N_REQ -> ARB.
    - Else if counter == MAX_GRANT_CYCLES-1 -> revoke: gnt=0, served[i]=1, rr_ptr advances, overrun pulse -> ARB.
    - Else if !win_q -> revoke with overrun pulse -> WAIT_WIN.
- Priority inside GRANT: done > timeout > window close. Simultaneous done and close gives no overrun.
- done on a non-granted index is ignored.
- req dropped while granted does not revoke. Only done, timeout or close revoke.
- Requesters still unserved when the window closes simply wait for the next frame. No state carries over except rr_ptr.
- Cycle counter is 10+ bits, sized $clog2(MAX_GRANT_CYCLES). It does not wrap: it is cleared on every GRANT entry.

## Timing
- Reset values:
  - gnt=0, frame_tick=0, overrun=0, overrun_cnt=0.
  - State WAIT_WIN, served=0, rr_ptr=0, counter=0, win_q=0.
- vcount reaches VBLANK_START, sampled at edge k:
  - win_q=1 and frame_tick=1 in cycle k+1.
  - State is ARB from k+1.
- Grant latency: eligible req sampled in ARB at edge m gives gnt high from m+1.
- After a release (done or revoke) at edge m, the earliest next grant is at m+2. There is one ARB cycle between grants.
- gnt is high for at most MAX_GRANT_CYCLES cycles.
- Window close: vcount reaches VTOTAL-GUARD_LINES at edge k. win_q=0 after k. gnt drops after edge k+1.
- Reset asserted mid-grant: gnt drops asynchronously.
- Reset released while vcount is inside the window: the first sampled win_q=1 counts as window open. frame_tick fires.

## Configuration
- Macro: VBLANK_ARB_OVERRUN_CNT_EN.
- Defined:
  - overrun_cnt increments on each overrun pulse and saturates at 255.
  - Cleared only by rst.
- Undefined:
  - overrun_cnt is tied to 0.
  - No counter logic is generated.
  - The overrun pulse is unaffected.

## Test plan
- Reset, then sweep vcount 0..925 with no req -> gnt stays 0. Exactly one frame_tick, one cycle after vcount=900 is sampled.
- req=2'b11 held and each owner pulses done 3 cycles after its grant -> gnt=01 then 10. Exactly 2 grants per frame. Grant order alternates across frames via rr_ptr.
- req[0] held and done never pulsed, MAX_GRANT_CYCLES=16 -> gnt[0] high exactly 16 cycles. overrun pulses once. overrun_cnt=1 when the macro is defined, 0 when it is not.
- Grant active when vcount steps 921->922 -> gnt drops one cycle after win_q falls. overrun=1. State WAIT_WIN. Next frame, the requester is granted again.
- done[i] and window close in the same cycle -> gnt drops, overrun stays 0, served[i]=1.
- rst asserted mid-grant and released at vcount=905 -> gnt=0 immediately, frame_tick pulses after release, and the arbiter grants index 0 first.
